// File: rtl/redux_pkg.sv
// Shared definitions for the Redux-V core: opcodes, FSM states,
// instruction classes, next-PC selects and ALU function codes.
package redux_pkg;

   // Opcode field values (instr[7:4]); 0x8-0xE are ALU operations.
   localparam logic [3:0] OP_BRZR = 4'h0;
   localparam logic [3:0] OP_JI   = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h4;
   localparam logic [3:0] OP_ST   = 4'h5;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP  = 3'd0,
      CLS_BRZR = 3'd1,
      CLS_JI   = 3'd2,
      CLS_LD   = 3'd3,
      CLS_ST   = 3'd4,
      CLS_ALU  = 3'd5,
      CLS_HALT = 3'd6
   } iclass_t;

   // Next-PC source select.
   localparam logic [1:0] PC_INC = 2'b00;   // PC + 1
   localparam logic [1:0] PC_REL = 2'b01;   // PC + sext(imm4)
   localparam logic [1:0] PC_REG = 2'b10;   // register b

   // ALU function codes, equal to op[2:0] of opcodes 0x8-0xE.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SHL = 3'b101;
   localparam logic [2:0] ALU_SHR = 3'b110;

   // True for the register-register ALU opcode range 0x8-0xE.
   function automatic logic is_alu_op(input logic [3:0] op);
      return op[3] && (op != OP_HALT);
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of the instruction register into an instruction
// class and its register/ALU fields.
module instr_decoder
   import redux_pkg::*;
(
   input  logic [7:0] ir,
   output logic [2:0] cls,
   output logic [1:0] ra,
   output logic [1:0] rb,
   output logic [2:0] alu_op
);

   assign ra     = ir[3:2];
   assign rb     = ir[1:0];
   assign alu_op = ir[6:4];

   // Classify the opcode; anything unassigned behaves as a NOP.
   always_comb begin
      cls = CLS_NOP;
      case (ir[7:4])
         OP_BRZR: cls = CLS_BRZR;
         OP_JI:   cls = CLS_JI;
         OP_LD:   cls = CLS_LD;
         OP_ST:   cls = CLS_ST;
         OP_HALT: cls = CLS_HALT;
         default: begin
            if (is_alu_op(ir[7:4])) begin
               cls = CLS_ALU;
            end else begin
               cls = CLS_NOP;
            end
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle control unit for the 8-bit Redux-V core. Outputs are
// registered per state; only the fetch strobes (qualified by mem_ready)
// and the BRZR PC write (qualified by zero) are gated by live inputs.
module control_unit
   import redux_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 32'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] instr,
   input  logic       mem_ready,
   input  logic       zero,
   output logic       mem_re,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_load,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic [1:0] r_a,
   output logic [1:0] r_b,
   output logic [1:0] write_addr,
   output logic       write_enable,
   output logic       wb_sel,
   output logic [2:0] alu_op,
   output logic       halted,
   output logic       error
);

   // A wait counter of 16 bits covers any practical timeout; the last
   // count value before expiry is precomputed.
   localparam logic        TO_EN   = (MEM_TIMEOUT != 32'd0);
   localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 32'd1);

   state_t      state_r;
   state_t      nxt_s;
   logic [7:0]  ir_r;
   logic [15:0] wait_cnt_r;
   logic        fetch_r;      // in FETCH: ir_load/pc_we follow mem_ready
   logic        pc_we_r;      // unconditional PC write (JI in EXEC)
   logic        brzr_r;       // conditional PC write (BRZR in EXEC)
   logic        waiting_s;
   logic        timeout_s;
   logic [2:0]  dec_cls;
   logic [1:0]  dec_ra;
   logic [1:0]  dec_rb;
   logic [2:0]  dec_alu_op;

   instr_decoder u_dec (
      .ir     (ir_r),
      .cls    (dec_cls),
      .ra     (dec_ra),
      .rb     (dec_rb),
      .alu_op (dec_alu_op)
   );

   assign ir_load = fetch_r & mem_ready;
   assign pc_we   = (fetch_r & mem_ready) | pc_we_r | (brzr_r & zero);

   // Next-state selection, including memory-wait timeout into HALT.
   always_comb begin
      waiting_s = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;
      timeout_s = TO_EN && waiting_s && (wait_cnt_r == TO_LAST);
      nxt_s     = state_r;
      case (state_r)
         ST_FETCH: begin
            if (mem_ready) begin
               nxt_s = ST_DECODE;
            end else if (timeout_s) begin
               nxt_s = ST_HALT;
            end else begin
               nxt_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            case (dec_cls)
               CLS_ALU, CLS_BRZR, CLS_JI: nxt_s = ST_EXEC;
               CLS_LD, CLS_ST:            nxt_s = ST_MEM;
               CLS_HALT:                  nxt_s = ST_HALT;
               default:                   nxt_s = ST_FETCH;
            endcase
         end
         ST_EXEC: begin
            if (dec_cls == CLS_ALU) begin
               nxt_s = ST_WB;
            end else begin
               nxt_s = ST_FETCH;
            end
         end
         ST_MEM: begin
            if (mem_ready) begin
               if (dec_cls == CLS_LD) begin
                  nxt_s = ST_WB;
               end else begin
                  nxt_s = ST_FETCH;
               end
            end else if (timeout_s) begin
               nxt_s = ST_HALT;
            end else begin
               nxt_s = ST_MEM;
            end
         end
         ST_WB:   nxt_s = ST_FETCH;
         ST_HALT: nxt_s = ST_HALT;
         default: nxt_s = ST_FETCH;
      endcase
   end

   // State, IR, wait counter and the registered outputs of the next state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ST_FETCH;
         ir_r         <= 8'h00;
         wait_cnt_r   <= 16'd0;
         fetch_r      <= 1'b1;
         pc_we_r      <= 1'b0;
         brzr_r       <= 1'b0;
         mem_re       <= 1'b1;
         mem_we       <= 1'b0;
         addr_sel     <= 1'b0;
         pc_src       <= PC_INC;
         r_a          <= 2'd0;
         r_b          <= 2'd0;
         write_addr   <= 2'd0;
         write_enable <= 1'b0;
         wb_sel       <= 1'b0;
         alu_op       <= 3'd0;
         halted       <= 1'b0;
         error        <= 1'b0;
      end else begin
         state_r <= nxt_s;

         if ((state_r == ST_FETCH) && mem_ready) begin
            ir_r <= instr;
         end else begin
            ir_r <= ir_r;
         end

         if (waiting_s && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
         end else begin
            wait_cnt_r <= 16'd0;
         end

         if (timeout_s) begin
            error <= 1'b1;
         end else begin
            error <= error;
         end

         // Everything idle unless the next state asks for it.
         fetch_r      <= 1'b0;
         pc_we_r      <= 1'b0;
         brzr_r       <= 1'b0;
         mem_re       <= 1'b0;
         mem_we       <= 1'b0;
         addr_sel     <= 1'b0;
         pc_src       <= PC_INC;
         r_a          <= 2'd0;
         r_b          <= 2'd0;
         write_addr   <= 2'd0;
         write_enable <= 1'b0;
         wb_sel       <= 1'b0;
         alu_op       <= 3'd0;
         halted       <= 1'b0;

         case (nxt_s)
            ST_FETCH: begin
               fetch_r <= 1'b1;
               mem_re  <= 1'b1;
            end
            ST_DECODE: begin
               // IR is being loaded on this edge, so take fields from instr.
               r_a <= instr[3:2];
               r_b <= instr[1:0];
            end
            ST_EXEC: begin
               r_a <= dec_ra;
               r_b <= dec_rb;
               case (dec_cls)
                  CLS_ALU: alu_op <= dec_alu_op;
                  CLS_BRZR: begin
                     brzr_r <= 1'b1;
                     pc_src <= PC_REG;
                  end
                  CLS_JI: begin
                     pc_we_r <= 1'b1;
                     pc_src  <= PC_REL;
                  end
                  default: alu_op <= 3'd0;
               endcase
            end
            ST_MEM: begin
               r_a      <= dec_ra;
               r_b      <= dec_rb;
               addr_sel <= 1'b1;
               if (dec_cls == CLS_LD) begin
                  mem_re <= 1'b1;
               end else begin
                  mem_we <= 1'b1;
               end
            end
            ST_WB: begin
               r_a          <= dec_ra;
               r_b          <= dec_rb;
               write_enable <= 1'b1;
               write_addr   <= dec_ra;
               if (dec_cls == CLS_LD) begin
                  wb_sel <= 1'b1;
               end else begin
                  wb_sel <= 1'b0;
                  alu_op <= dec_alu_op;
               end
            end
            ST_HALT: begin
               halted <= 1'b1;
            end
            default: begin
               fetch_r <= 1'b1;
               mem_re  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a vector table of single instructions
// with zero-wait memory, plus hand sequences for waits, PC wrap, HALT,
// timeout and reset during an access.
module tb_control_unit;
   import redux_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] instr = 8'h00;
   logic       mem_ready = 1'b0;
   logic       zero = 1'b0;

   logic       mem_re, mem_we, addr_sel, ir_load, pc_we, write_enable, wb_sel, halted, error;
   logic [1:0] pc_src, r_a, r_b, write_addr;
   logic [2:0] alu_op;

   logic       mem_re_t, mem_we_t, addr_sel_t, ir_load_t, pc_we_t, write_enable_t, wb_sel_t, halted_t, error_t;
   logic [1:0] pc_src_t, r_a_t, r_b_t, write_addr_t;
   logic [2:0] alu_op_t;

   control_unit u_dut (
      .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .zero(zero),
      .mem_re(mem_re), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
      .pc_we(pc_we), .pc_src(pc_src), .r_a(r_a), .r_b(r_b), .write_addr(write_addr),
      .write_enable(write_enable), .wb_sel(wb_sel), .alu_op(alu_op),
      .halted(halted), .error(error)
   );

   control_unit #(.MEM_TIMEOUT(32'd4)) u_to (
      .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .zero(zero),
      .mem_re(mem_re_t), .mem_we(mem_we_t), .addr_sel(addr_sel_t), .ir_load(ir_load_t),
      .pc_we(pc_we_t), .pc_src(pc_src_t), .r_a(r_a_t), .r_b(r_b_t), .write_addr(write_addr_t),
      .write_enable(write_enable_t), .wb_sel(wb_sel_t), .alu_op(alu_op_t),
      .halted(halted_t), .error(error_t)
   );

   always #5 clk = ~clk;

   logic [18:0] act;
   assign act = {mem_re, mem_we, addr_sel, ir_load, pc_we, pc_src, r_a, r_b,
                 write_addr, write_enable, wb_sel, alu_op, halted};

   // Bench-side PC driven only by the DUT's pc_we/pc_src.
   logic [7:0] pc_m;
   always @(posedge clk) begin
      if (!reset) pc_m <= 8'h00;
      else if (pc_we) begin
         case (pc_src)
            2'b00:   pc_m <= pc_m + 8'd1;
            2'b01:   pc_m <= pc_m + {{4{instr[3]}}, instr[3:0]};
            default: pc_m <= 8'hAA;
         endcase
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [18:0] ov(input logic mre, input logic mwe, input logic asel,
                                      input logic irl, input logic pwe, input logic [1:0] psrc,
                                      input logic [1:0] ra, input logic [1:0] rb,
                                      input logic [1:0] wa, input logic we, input logic wbs,
                                      input logic [2:0] aop, input logic hlt);
      return {mre, mwe, asel, irl, pwe, psrc, ra, rb, wa, we, wbs, aop, hlt};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, got, want);
      end
   endtask

   typedef struct {
      logic [7:0]       instr;
      logic             zero;
      int               n;
      logic [4:0][18:0] exp;
   } vec_t;
   vec_t vecs [$];

   task automatic add_vec(input logic [7:0] i, input logic z, input int n,
                          input logic [18:0] e0, input logic [18:0] e1, input logic [18:0] e2,
                          input logic [18:0] e3, input logic [18:0] e4);
      vec_t v;
      v.instr = i; v.zero = z; v.n = n;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   logic [18:0] e_f, e_idle, e_halt, e_z;

   initial begin
      e_f    = ov(1'b1,1'b0,1'b0,1'b1,1'b1,2'd0,2'd0,2'd0,2'd0,1'b0,1'b0,3'd0,1'b0); // FETCH, ready high
      e_idle = ov(1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,1'b0,3'd0,1'b0); // FETCH, ready low
      e_halt = ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,2'd0,1'b0,1'b0,3'd0,1'b1);
      e_z    = 19'd0;

      // ADD r2,r1
      add_vec(8'h89, 1'b0, 5, e_f,
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd0,1'b0,1'b0,3'd0,1'b0),
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd0,1'b0,1'b0,3'd0,1'b0),
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,2'd2,1'b1,1'b0,3'd0,1'b0), e_f);
      // ALU op 3 on r3,r2; zero high must not produce a PC write
      add_vec(8'hBE, 1'b1, 5, e_f,
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd3,2'd2,2'd0,1'b0,1'b0,3'd0,1'b0),
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd3,2'd2,2'd0,1'b0,1'b0,3'd3,1'b0),
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd3,2'd2,2'd3,1'b1,1'b0,3'd3,1'b0), e_f);
      // LD r1,[r3]
      add_vec(8'h47, 1'b0, 5, e_f,
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0),
              ov(1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,2'd1,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0),
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd3,2'd1,1'b1,1'b1,3'd0,1'b0), e_f);
      // ST r2,[r3]
      add_vec(8'h5B, 1'b0, 4, e_f,
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0),
              ov(1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd2,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0), e_f, e_z);
      // BRZR taken
      add_vec(8'h06, 1'b1, 4, e_f,
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd2,2'd0,1'b0,1'b0,3'd0,1'b0),
              ov(1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd1,2'd2,2'd0,1'b0,1'b0,3'd0,1'b0), e_f, e_z);
      // BRZR not taken
      add_vec(8'h06, 1'b0, 4, e_f,
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd2,2'd0,1'b0,1'b0,3'd0,1'b0),
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd1,2'd2,2'd0,1'b0,1'b0,3'd0,1'b0), e_f, e_z);
      // JI -1
      add_vec(8'h1F, 1'b0, 4, e_f,
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd3,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0),
              ov(1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,2'd3,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0), e_f, e_z);
      // NOPs
      add_vec(8'h20, 1'b0, 3, e_f, e_z, e_f, e_z, e_z);
      add_vec(8'h7F, 1'b0, 3, e_f,
              ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd3,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0), e_f, e_z, e_z);
      // HALT
      add_vec(8'hF0, 1'b0, 4, e_f, e_z, e_halt, e_halt, e_z);

      // Reset state with memory not ready
      mem_ready = 1'b0;
      do_reset();
      @(negedge clk);
      chk("reset_outputs", {13'd0, act}, {13'd0, e_idle});
      chk("reset_error", {31'd0, error}, 32'd0);

      // Table of single instructions with zero-wait memory
      for (int i = 0; i < vecs.size(); i++) begin
         instr = vecs[i].instr;
         zero = vecs[i].zero;
         mem_ready = 1'b1;
         do_reset();
         for (int k = 0; k < vecs[i].n; k++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_%h_c%0d", i, vecs[i].instr, k + 1), {13'd0, act}, {13'd0, vecs[i].exp[k]});
         end
      end

      // LD with three wait cycles in MEM
      zero = 1'b0;
      instr = 8'h47;
      mem_ready = 1'b1;
      do_reset();
      step();
      mem_ready = 1'b0;              // ignored in DECODE
      @(negedge clk);
      chk("ldw_decode", {13'd0, act}, {13'd0, ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0)});
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk);
         chk($sformatf("ldw_mem_wait%0d", k), {13'd0, act}, {13'd0, ov(1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,2'd1,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0)});
      end
      step();
      mem_ready = 1'b1;
      @(negedge clk);
      chk("ldw_mem_done", {13'd0, act}, {13'd0, ov(1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,2'd1,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0)});
      step();
      @(negedge clk);
      chk("ldw_wb", {13'd0, act}, {13'd0, ov(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd3,2'd1,1'b1,1'b1,3'd0,1'b0)});

      // JI sequence with wrap-around of the modelled PC
      instr = 8'h1F;
      mem_ready = 1'b1;
      do_reset();
      step(); step(); step();
      chk("ji_m1_from_00", {24'd0, pc_m}, 32'h00);
      instr = 8'h1E;
      step(); step(); step();
      chk("ji_m2_to_ff", {24'd0, pc_m}, 32'hFF);
      instr = 8'h1F;
      step(); step(); step();
      chk("ji_m1_from_ff", {24'd0, pc_m}, 32'hFF);
      instr = 8'h18;
      step(); step(); step();
      chk("ji_m8_to_f8", {24'd0, pc_m}, 32'hF8);

      // HALT holds with no strobes until reset
      instr = 8'hF0;
      mem_ready = 1'b1;
      do_reset();
      step(); step();
      @(negedge clk);
      chk("halt_cycle3", {13'd0, act}, {13'd0, e_halt});
      for (int k = 0; k < 20; k++) begin
         step();
         @(negedge clk);
         chk($sformatf("halt_hold%0d", k), {13'd0, act}, {13'd0, e_halt});
      end
      mem_ready = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("halt_reset_fetch", {13'd0, act}, {13'd0, e_idle});

      // Fetch timeout on the MEM_TIMEOUT=4 instance
      mem_ready = 1'b0;
      do_reset();
      step(); step(); step();
      @(negedge clk);
      chk("to_err_cycle4", {30'd0, error_t, halted_t}, 32'd0);
      step();
      @(negedge clk);
      chk("to_err_cycle5", {30'd0, error_t, halted_t}, 32'd3);
      chk("to_none_waits", {13'd0, act}, {13'd0, e_idle});
      chk("to_none_error", {31'd0, error}, 32'd0);
      mem_ready = 1'b1;
      step(); step(); step();
      @(negedge clk);
      chk("to_sticky", {29'd0, error_t, halted_t, ir_load_t}, 32'd6);
      mem_ready = 1'b0;
      do_reset();
      @(negedge clk);
      chk("to_reset_clears", {29'd0, error_t, halted_t, mem_re_t}, 32'd1);

      // Reset during an ST wait abandons the write
      instr = 8'h5B;
      mem_ready = 1'b1;
      do_reset();
      step();
      mem_ready = 1'b0;
      step();
      @(negedge clk);
      chk("st_wait_we", {13'd0, act}, {13'd0, ov(1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd2,2'd3,2'd0,1'b0,1'b0,3'd0,1'b0)});
      step();
      @(negedge clk);
      chk("st_wait_we2", {31'd0, mem_we}, 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("st_reset_abandon", {13'd0, act}, {13'd0, e_idle});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
